// File: rtl/pwm_ctrl_pkg.sv
// Shared types and defaults for the button-driven duty controller.
package pwm_ctrl_pkg;

  localparam int DUTY_W         = 7;
  localparam int DUTY_MAX_DEF   = 100;
  localparam int STEP_DEF       = 5;
  localparam int HOLD_CYC_DEF   = 50_000_000;
  localparam int REPEAT_CYC_DEF = 10_000_000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HOLD = 2'd1,
    ST_REPEAT    = 2'd2,
    ST_WAIT_REL  = 2'd3
  } state_e;

  // One saturating step, done one bit wider than the duty so nothing wraps.
  function automatic logic [DUTY_W-1:0] step_duty(
    input logic [DUTY_W-1:0] duty,
    input logic              up,
    input logic [DUTY_W:0]   step,
    input logic [DUTY_W:0]   lim
  );
    logic [DUTY_W:0] wide;
    wide = {1'b0, duty};
    if (up) begin
      wide = wide + step;
      if (wide > lim) wide = lim;
    end else if (wide < step) begin
      wide = '0;
    end else begin
      wide = wide - step;
    end
    return wide[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/btn_duty_ctrl_if.sv
// Button inputs and duty outputs of btn_duty_ctrl, bundled for port connection.
interface btn_duty_ctrl_if;
  import pwm_ctrl_pkg::*;

  logic              btn_up;
  logic              btn_dn;
  logic [DUTY_W-1:0] duty;
  logic              duty_chg;
  logic              at_limit;

  modport master (output btn_up, btn_dn, input duty, duty_chg, at_limit);
  modport slave  (input btn_up, btn_dn, output duty, duty_chg, at_limit);
endinterface

// File: rtl/btn_duty_ctrl_edge_detect.sv
// Registered rising-edge detector for one debounced button level.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);
  logic prev_q;
  logic armed_q;
  logic rise_q;

  // armed_q masks the first cycle after reset so a button held through reset is not a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      prev_q  <= level_i;
      armed_q <= 1'b1;
      rise_q  <= level_i & ~prev_q & armed_q;
    end
  end

  assign rise_o = rise_q;
endmodule

// File: rtl/btn_duty_ctrl.sv
// Up/down button duty setting with optional hold-to-repeat (macro BTN_AUTO_REPEAT_EN).
//   state     | meaning
//   IDLE      | waiting for a single clean press
//   WAIT_HOLD | active button held, counting to auto-repeat
//   REPEAT    | stepping every REPEAT_CYC while held
//   WAIT_REL  | ignore buttons until both are released
module btn_duty_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_MAX   = DUTY_MAX_DEF,
  parameter int STEP       = STEP_DEF,
  parameter int DUTY_RST   = 0,
  parameter int HOLD_CYC   = HOLD_CYC_DEF,
  parameter int REPEAT_CYC = REPEAT_CYC_DEF
) (
  input logic            clk,
  input logic            rst,
  btn_duty_ctrl_if.slave bus
);
  localparam logic [DUTY_W:0]   LIM       = DUTY_MAX[DUTY_W:0];
  localparam logic [DUTY_W:0]   STEP_V    = STEP[DUTY_W:0];
  localparam logic [DUTY_W-1:0] DUTY_RST_V = DUTY_RST[DUTY_W-1:0];
  localparam logic              LIM_RST   = (DUTY_RST == 0) || (DUTY_RST == DUTY_MAX);

`ifdef BTN_AUTO_REPEAT_EN
  localparam int CNT_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LD  = CNT_W'(REPEAT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             act_lvl, oth_lvl;
`endif

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic              step_en;
  logic              rise_up, rise_dn;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              chg_q, chg_d;
  logic              lim_q, lim_d;

  edge_detect u_edge_up (.clk(clk), .rst(rst), .level_i(bus.btn_up), .rise_o(rise_up));
  edge_detect u_edge_dn (.clk(clk), .rst(rst), .level_i(bus.btn_dn), .rise_o(rise_dn));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b1;
      duty_q  <= DUTY_RST_V;
      chg_q   <= 1'b0;
      lim_q   <= LIM_RST;
`ifdef BTN_AUTO_REPEAT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      duty_q  <= duty_d;
      chg_q   <= chg_d;
      lim_q   <= lim_d;
`ifdef BTN_AUTO_REPEAT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    step_en = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
    cnt_d   = '0;
    act_lvl = dir_q ? bus.btn_up : bus.btn_dn;
    oth_lvl = dir_q ? bus.btn_dn : bus.btn_up;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rise_up || rise_dn) begin
          if (rise_up && !rise_dn && !bus.btn_dn) begin
            step_en = 1'b1;
            dir_d   = 1'b1;
          end else if (rise_dn && !rise_up && !bus.btn_up) begin
            step_en = 1'b1;
            dir_d   = 1'b0;
          end
`ifdef BTN_AUTO_REPEAT_EN
          state_d = step_en ? ST_WAIT_HOLD : ST_WAIT_REL;
          cnt_d   = step_en ? HOLD_LD : '0;
`else
          state_d = ST_WAIT_REL;
`endif
        end
      end
`ifdef BTN_AUTO_REPEAT_EN
      ST_WAIT_HOLD, ST_REPEAT: begin
        if (!act_lvl) begin
          state_d = ST_IDLE;
        end else if (oth_lvl) begin
          state_d = ST_WAIT_REL;
        end else if (cnt_q == '0) begin
          step_en = 1'b1;
          state_d = ST_REPEAT;
          cnt_d   = REP_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      ST_WAIT_REL: begin
        if (!bus.btn_up && !bus.btn_dn) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    duty_d = duty_q;
    chg_d  = 1'b0;
    if (step_en) begin
      duty_d = step_duty(duty_q, dir_d, STEP_V, LIM);
      chg_d  = (duty_d != duty_q);
    end
    lim_d = (duty_d == '0) || ({1'b0, duty_d} == LIM);
  end

  assign bus.duty     = duty_q;
  assign bus.duty_chg = chg_q;
  assign bus.at_limit = lim_q;
endmodule

// File: tb/tb_btn_duty_ctrl.sv
// Directed bench for btn_duty_ctrl: three instances at DUTY_RST 0, 98 and 50.
module tb_btn_duty_ctrl;
  import pwm_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_duty_ctrl_if if0 ();
  btn_duty_ctrl_if if1 ();
  btn_duty_ctrl_if if2 ();

  btn_duty_ctrl #(.DUTY_MAX(100), .STEP(5), .DUTY_RST(0),  .HOLD_CYC(10), .REPEAT_CYC(4))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  btn_duty_ctrl #(.DUTY_MAX(100), .STEP(5), .DUTY_RST(98), .HOLD_CYC(10), .REPEAT_CYC(4))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  btn_duty_ctrl #(.DUTY_MAX(100), .STEP(5), .DUTY_RST(50), .HOLD_CYC(10), .REPEAT_CYC(4))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [2:0]      up, dn, chg, lim;
  logic [2:0][6:0] duty;

  assign if0.btn_up = up[0];
  assign if1.btn_up = up[1];
  assign if2.btn_up = up[2];
  assign if0.btn_dn = dn[0];
  assign if1.btn_dn = dn[1];
  assign if2.btn_dn = dn[2];
  assign duty[0] = if0.duty;
  assign duty[1] = if1.duty;
  assign duty[2] = if2.duty;
  assign chg[0]  = if0.duty_chg;
  assign chg[1]  = if1.duty_chg;
  assign chg[2]  = if2.duty_chg;
  assign lim[0]  = if0.at_limit;
  assign lim[1]  = if1.at_limit;
  assign lim[2]  = if2.at_limit;

  int n_pass = 0;
  int n_chk  = 0;
  int exp_d[3];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input int i, input string tag, input bit exp_chg);
    chk({tag, " duty"}, int'(duty[i]), exp_d[i]);
    chk({tag, " chg"},  int'(chg[i]),  int'(exp_chg));
    chk({tag, " lim"},  int'(lim[i]),  int'(exp_d[i] == 0 || exp_d[i] == 100));
  endtask

  // Step times relative to the button rise, for a press held n cycles.
  function automatic bit is_step(input int t, input int n);
`ifdef BTN_AUTO_REPEAT_EN
    return (t == 2) || (t >= 12 && t <= n && (t - 12) % 4 == 0);
`else
    return (t == 2) && (n > 0);
`endif
  endfunction

  task automatic model_step(input int i, input bit dir, input int t, input int n, output bit c);
    int nxt;
    c = 1'b0;
    if (is_step(t, n)) begin
      if (dir) nxt = (exp_d[i] + 5 > 100) ? 100 : exp_d[i] + 5;
      else     nxt = (exp_d[i] < 5) ? 0 : exp_d[i] - 5;
      c = (nxt != exp_d[i]);
      exp_d[i] = nxt;
    end
  endtask

  task automatic hold(input int i, input bit dir, input int n, input string tag);
    bit c;
    if (dir) up[i] = 1'b1; else dn[i] = 1'b1;
    for (int t = 1; t <= n + 3; t++) begin
      tick();
      model_step(i, dir, t, n, c);
      check_state(i, tag, c);
      if (t == n) begin
        up[i] = 1'b0;
        dn[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_d[0] = 0;
    exp_d[1] = 98;
    exp_d[2] = 50;
    #1;
    for (int i = 0; i < 3; i++) check_state(i, "rst", 1'b0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    bit c;
    rst = 1'b1;
    up  = '0;
    dn  = '0;
    tick();
    do_reset();

    hold(0, 1'b1, 3, "press_up");

    do_reset();
    hold(0, 1'b1, 30, "hold_up");

    hold(1, 1'b1, 3, "lim_up1");
    hold(1, 1'b1, 3, "lim_up2");
    hold(1, 1'b0, 3, "lim_dn");

    up[0] = 1'b1;
    dn[0] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      check_state(0, "both", 1'b0);
    end
    up[0] = 1'b0;
    dn[0] = 1'b0;
    repeat (3) tick();
    hold(0, 1'b0, 3, "dn_after_both");

    do_reset();
    up[0] = 1'b1;
    for (int t = 1; t <= 13; t++) begin
      tick();
      model_step(0, 1'b1, t, 13, c);
      check_state(0, "pre_rst", c);
    end
    do_reset();
    for (int t = 0; t < 20; t++) begin
      tick();
      check_state(0, "held_thru_rst", 1'b0);
    end
    up[0] = 1'b0;
    tick();
    tick();
    hold(0, 1'b1, 3, "repress");

    hold(2, 1'b0, 40, "hold_dn");

    dn[0] = 1'b1;
    do_reset();
    tick();
    up[0] = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      check_state(0, "up_while_dn", 1'b0);
    end
    up[0] = 1'b0;
    dn[0] = 1'b0;
    repeat (3) tick();
    hold(0, 1'b1, 3, "after_rel");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/btn_duty_ctrl.md
BTN_DUTY_CTRL -- requirements
Module: btn_duty_ctrl

Interface
REQ-001 Parameter DUTY_MAX, default 100: upper duty limit, 1..127.
REQ-002 Parameter STEP, default 5: duty increment/decrement per event, 1..DUTY_MAX.
REQ-003 Parameter DUTY_RST, default 0: duty value after reset, 0..DUTY_MAX.
REQ-004 Parameter HOLD_CYC, default 50_000_000: cycles a button is held before auto-repeat starts (0.5 s at 100 MHz).
REQ-005 Parameter REPEAT_CYC, default 10_000_000: cycles between auto-repeat steps.
REQ-006 clk  input  1  100 MHz system clock; all logic on the rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 btn_up  input  1  debounced, clk-synchronous level of the "up" button (1 = pressed).
REQ-009 btn_dn  input  1  debounced, clk-synchronous level of the "down" button (1 = pressed).
REQ-010 duty  output  7  current duty setting, unsigned, 0..DUTY_MAX, registered.
REQ-011 duty_chg  output  1  one-cycle pulse, high in the same cycle duty takes a new value.
REQ-012 at_limit  output  1  registered; high while duty == 0 or duty == DUTY_MAX.

Function
REQ-013 Rising edges of btn_up and btn_dn SHALL be detected with a one-register delay; each edge is a press event.
REQ-014 FSM states: IDLE, WAIT_HOLD, REPEAT, WAIT_REL.
REQ-015 IDLE: a rise on exactly one button applies one step in that direction, loads the hold counter, and moves to WAIT_HOLD.
REQ-016 Simultaneous rises, or a rise on one button while the other is held, SHALL cause no step; the FSM moves to WAIT_REL.
REQ-017 WAIT_HOLD: active button released -> IDLE; other button pressed -> WAIT_REL; HOLD_CYC cycles elapsed -> step, load repeat counter, REPEAT.
REQ-018 REPEAT: one step every REPEAT_CYC cycles while the active button alone is held; release -> IDLE; other button pressed -> WAIT_REL.
REQ-019 WAIT_REL: no steps; return to IDLE only when both buttons read 0.
REQ-020 Step up: duty = min(duty + STEP, DUTY_MAX). Step down: duty = max(duty - STEP, 0). Computed 8 bits wide, with no wrap-around.
REQ-021 duty_chg SHALL pulse only if the new value differs from the old; a step at a limit leaves duty unchanged with no pulse.
REQ-022 duty updates exactly one cycle after the detected edge, i.e. two cycles after btn_* rises.
REQ-023 Counters SHALL be wide enough for max(HOLD_CYC, REPEAT_CYC) and SHALL clear on every state change.

Reset
REQ-024 With rst high: duty = DUTY_RST, duty_chg = 0, at_limit matches DUTY_RST, FSM = IDLE, counters = 0, edge registers = 0.
REQ-025 Reset asserted mid-hold or mid-repeat SHALL abort immediately; after release, a button still held SHALL NOT count as a press until it is released and pressed again.

Configuration
REQ-026 Macro BTN_AUTO_REPEAT_EN defined: WAIT_HOLD and REPEAT behave as in REQ-017 and REQ-018.
REQ-027 Macro BTN_AUTO_REPEAT_EN undefined: WAIT_HOLD and REPEAT are never entered, the hold and repeat counters are not built, and each press yields exactly one step, then WAIT_REL.

Structure
REQ-028 Shared package pwm_ctrl_pkg SHALL hold the FSM state encoding, the duty width (7), and the default DUTY_MAX, STEP, HOLD_CYC and REPEAT_CYC values.
REQ-029 One sub-module, edge_detect (level in, registered rise pulse out), SHALL be instantiated once per button.

Verification
Simulation parameters: HOLD_CYC=10, REPEAT_CYC=4, STEP=5, DUTY_MAX=100, DUTY_RST=0.
REQ-030 Reset, then a 3-cycle btn_up press -> duty 0→5 two cycles after the rise, one duty_chg pulse, at_limit 1→0.
REQ-031 Hold btn_up 30 cycles with auto-repeat -> steps at t=2, 12, 16, 20, 24, 28 (relative), duty = 30.
REQ-032 From duty = 98 (DUTY_RST=98), press up -> 100 with a pulse and at_limit = 1; press again -> stays 100 with no pulse.
REQ-033 btn_up and btn_dn rise in the same cycle, both held 20 cycles -> duty unchanged and no pulse; release both, press dn -> duty − 5.
REQ-034 Assert rst at cycle 13 of an up hold, keep btn_up high through reset release -> duty = DUTY_RST and no step until btn_up goes low then high.
REQ-035 Build without BTN_AUTO_REPEAT_EN, hold btn_dn 40 cycles from duty = 50 -> exactly one step, to 45.
